// File: rtl/bsram_sd_sync.sv
`default_nettype none
// bsram_sd_sync: serialises BSRAM load/save/autosave sector transfers over the hps_io
// sd_lba/sd_rd/sd_wr/sd_ack handshake, tracks dirty state and flags timeouts.
module bsram_sd_sync #(
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        BK_ENA,
    input  logic [23:0] RAM_MASK,
    input  logic        LOAD_REQ,
    input  logic        SAVE_REQ,
    input  logic        AUTO_LOAD,
    input  logic        OSD_STATUS,
    input  logic        AUTOSAVE_EN,
    input  logic        BSRAM_WR,
    input  logic        SD_ACK,
    output logic [31:0] SD_LBA,
    output logic        SD_RD,
    output logic        SD_WR,
    output logic        LOADING,
    output logic        BUSY,
    output logic        DIRTY,
    output logic        DONE,
    output logic        ERROR
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic          load_q, save_q, osd_q, ack_q;
    logic          load_trig, save_trig, osd_trig;
    logic [14:0]   lba, lba_nxt;
    logic          dir, dir_nxt;
    logic          rd, rd_nxt, wr, wr_nxt;
    logic          loading, loading_nxt;
    logic          dirty, dirty_nxt;
    logic          done, done_nxt;
    logic          error, error_nxt;
    logic [TW-1:0] tcnt, tcnt_nxt;

    logic          valid, save_go, timeout;
    logic [14:0]   last;

    assign valid   = BK_ENA & (RAM_MASK != 24'd0);
    assign last    = RAM_MASK[23:9];
    assign save_go = save_trig | (osd_trig & AUTOSAVE_EN & dirty);
    assign timeout = (tcnt == TW'(TIMEOUT_CYCLES - 1));

    // Edge detection is registered, so triggers reach the FSM one cycle after the input edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            load_q    <= 1'b0;
            save_q    <= 1'b0;
            osd_q     <= 1'b0;
            ack_q     <= 1'b0;
            load_trig <= 1'b0;
            save_trig <= 1'b0;
            osd_trig  <= 1'b0;
        end else begin
            load_q    <= LOAD_REQ;
            save_q    <= SAVE_REQ;
            osd_q     <= OSD_STATUS;
            ack_q     <= SD_ACK;
            load_trig <= (LOAD_REQ & ~load_q) | AUTO_LOAD;
            save_trig <= SAVE_REQ & ~save_q;
            osd_trig  <= OSD_STATUS & ~osd_q;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= IDLE;
            lba     <= 15'd0;
            dir     <= 1'b0;
            rd      <= 1'b0;
            wr      <= 1'b0;
            loading <= 1'b0;
            dirty   <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            tcnt    <= '0;
        end else begin
            state   <= state_nxt;
            lba     <= lba_nxt;
            dir     <= dir_nxt;
            rd      <= rd_nxt;
            wr      <= wr_nxt;
            loading <= loading_nxt;
            dirty   <= dirty_nxt;
            done    <= done_nxt;
            error   <= error_nxt;
            tcnt    <= tcnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        lba_nxt     = lba;
        dir_nxt     = dir;
        rd_nxt      = rd;
        wr_nxt      = wr;
        loading_nxt = loading;
        dirty_nxt   = dirty;
        done_nxt    = 1'b0;
        error_nxt   = error;
        tcnt_nxt    = '0;

        case (state)
            IDLE: begin
                if (valid && (load_trig || save_go)) begin
                    lba_nxt     = 15'd0;
                    dir_nxt     = load_trig;
                    error_nxt   = 1'b0;
                    loading_nxt = load_trig;
                    rd_nxt      = load_trig;
                    wr_nxt      = ~load_trig;
                    if (!load_trig) dirty_nxt = 1'b0;
                    state_nxt   = REQ;
                end
            end
            REQ: begin
                if (SD_ACK && !ack_q) begin
                    rd_nxt    = 1'b0;
                    wr_nxt    = 1'b0;
                    state_nxt = XFER;
                end else if (timeout) begin
                    rd_nxt      = 1'b0;
                    wr_nxt      = 1'b0;
                    loading_nxt = 1'b0;
                    error_nxt   = 1'b1;
                    if (!dir) dirty_nxt = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    tcnt_nxt = tcnt + 1'b1;
                end
            end
            XFER: begin
                if (!SD_ACK && ack_q) begin
                    if (lba == last) begin
                        done_nxt    = 1'b1;
                        loading_nxt = 1'b0;
                        if (dir) dirty_nxt = 1'b0;
                        state_nxt   = IDLE;
                    end else begin
                        lba_nxt   = lba + 15'd1;
                        rd_nxt    = dir;
                        wr_nxt    = ~dir;
                        state_nxt = REQ;
                    end
                end else if (timeout) begin
                    rd_nxt      = 1'b0;
                    wr_nxt      = 1'b0;
                    loading_nxt = 1'b0;
                    error_nxt   = 1'b1;
                    if (!dir) dirty_nxt = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    tcnt_nxt = tcnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Core writes outside a load always win over any clear in the same cycle.
        if (BSRAM_WR && !loading) dirty_nxt = 1'b1;
    end

    assign SD_LBA  = {17'd0, lba};
    assign SD_RD   = rd;
    assign SD_WR   = wr;
    assign LOADING = loading;
    assign BUSY    = (state != IDLE);
    assign DIRTY   = dirty;
    assign DONE    = done;
    assign ERROR   = error;

endmodule
`default_nettype wire

// File: tb/tb_bsram_sd_sync.sv
`default_nettype none
// Directed self-checking bench for bsram_sd_sync with a simple hps_io sector-ack model.
module tb_bsram_sd_sync;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        BK_ENA, LOAD_REQ, SAVE_REQ, AUTO_LOAD, OSD_STATUS, AUTOSAVE_EN, BSRAM_WR, SD_ACK;
    logic [23:0] RAM_MASK;
    logic [31:0] SD_LBA;
    logic        SD_RD, SD_WR, LOADING, BUSY, DIRTY, DONE, ERROR;

    bsram_sd_sync #(.TIMEOUT_CYCLES(100)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .BK_ENA(BK_ENA), .RAM_MASK(RAM_MASK),
        .LOAD_REQ(LOAD_REQ), .SAVE_REQ(SAVE_REQ), .AUTO_LOAD(AUTO_LOAD),
        .OSD_STATUS(OSD_STATUS), .AUTOSAVE_EN(AUTOSAVE_EN), .BSRAM_WR(BSRAM_WR),
        .SD_ACK(SD_ACK), .SD_LBA(SD_LBA), .SD_RD(SD_RD), .SD_WR(SD_WR),
        .LOADING(LOADING), .BUSY(BUSY), .DIRTY(DIRTY), .DONE(DONE), .ERROR(ERROR)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Activity observed by the monitor, cleared per scenario.
    int   rd_reqs, wr_reqs, seq_err, overlap, done_cnt, rd_noload;
    int   last_lba;
    bit   loading_seen;
    bit   ack_en;

    typedef struct {
        int          trig;        // 0 load, 1 save, 2 both
        logic        bk;
        logic [23:0] mask;
        int          exp_rd;
        int          exp_wr;
        int          exp_last;
        int          exp_done;
        int          exp_loading;
        int          exp_dirty;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        rd_reqs = 0; wr_reqs = 0; seq_err = 0; overlap = 0;
        done_cnt = 0; rd_noload = 0; last_lba = 0; loading_seen = 0;
    endtask

    task automatic run_xfer(output bit went_busy, output bit timed_out);
        went_busy = 0;
        timed_out = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (BUSY) begin went_busy = 1; break; end
        end
        if (went_busy) begin
            timed_out = 1;
            for (int i = 0; i < 3000; i++) begin
                @(negedge CLK);
                if (!BUSY) begin timed_out = 0; break; end
            end
        end
        repeat (3) @(negedge CLK);
    endtask

    task automatic write_pulse();
        @(negedge CLK); BSRAM_WR = 1'b1;
        @(negedge CLK); BSRAM_WR = 1'b0;
    endtask

    // hps_io model: ack 10 cycles after a request is seen, hold ack 20 cycles.
    initial begin
        SD_ACK = 1'b0;
        forever begin
            @(negedge CLK);
            if (ack_en && (SD_RD || SD_WR)) begin
                repeat (9) @(negedge CLK);
                SD_ACK = 1'b1;
                repeat (20) @(negedge CLK);
                SD_ACK = 1'b0;
            end
        end
    end

    initial begin
        logic prev_rd, prev_wr;
        prev_rd = 1'b0; prev_wr = 1'b0;
        forever begin
            @(negedge CLK);
            if (SD_RD && SD_WR) overlap++;
            if (SD_RD && !LOADING) rd_noload++;
            if ((SD_RD && !prev_rd) || (SD_WR && !prev_wr)) begin
                if (SD_LBA != 32'(rd_reqs + wr_reqs)) seq_err++;
                last_lba = int'(SD_LBA);
                if (SD_RD) rd_reqs++; else wr_reqs++;
            end
            if (DONE) done_cnt++;
            if (LOADING) loading_seen = 1;
            prev_rd = SD_RD; prev_wr = SD_WR;
        end
    end

    initial begin
        bit wb, to;
        vecs[0] = '{0, 1'b1, 24'h001FFF, 16, 0, 15, 1, 1, 0};
        vecs[1] = '{1, 1'b1, 24'h0007FF, 0, 4, 3, 1, 0, 0};
        vecs[2] = '{0, 1'b1, 24'h0000FF, 1, 0, 0, 1, 1, 0};
        vecs[3] = '{1, 1'b0, 24'h0007FF, 0, 0, 0, 0, 0, 1};
        vecs[4] = '{0, 1'b1, 24'h000000, 0, 0, 0, 0, 0, 1};
        vecs[5] = '{2, 1'b1, 24'h0003FF, 2, 0, 1, 1, 1, 0};

        RESET_N = 1'b0; BK_ENA = 1'b1; RAM_MASK = 24'h0007FF;
        LOAD_REQ = 0; SAVE_REQ = 0; AUTO_LOAD = 0; OSD_STATUS = 0;
        AUTOSAVE_EN = 0; BSRAM_WR = 0; ack_en = 0;
        clear_mon();
        repeat (3) @(negedge CLK);
        check("rst_sd_rd", SD_RD, 0);
        check("rst_sd_wr", SD_WR, 0);
        check("rst_busy", BUSY, 0);
        check("rst_flags", {LOADING, DIRTY, DONE, ERROR}, 0);
        check("rst_lba", SD_LBA, 0);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLK);

        // Table-driven transfers
        ack_en = 1;
        for (int i = 0; i < 6; i++) begin
            BK_ENA = vecs[i].bk;
            RAM_MASK = vecs[i].mask;
            write_pulse();
            @(negedge CLK);
            check($sformatf("v%0d_pre_dirty", i), DIRTY, 1);
            clear_mon();
            LOAD_REQ = (vecs[i].trig != 1);
            SAVE_REQ = (vecs[i].trig != 0);
            repeat (2) @(negedge CLK);
            LOAD_REQ = 0; SAVE_REQ = 0;
            run_xfer(wb, to);
            check($sformatf("v%0d_timeout", i), to, 0);
            check($sformatf("v%0d_busy", i), wb, (vecs[i].exp_done != 0));
            check($sformatf("v%0d_rd", i), rd_reqs, vecs[i].exp_rd);
            check($sformatf("v%0d_wr", i), wr_reqs, vecs[i].exp_wr);
            check($sformatf("v%0d_last", i), last_lba, vecs[i].exp_last);
            check($sformatf("v%0d_done", i), done_cnt, vecs[i].exp_done);
            check($sformatf("v%0d_loading", i), loading_seen, vecs[i].exp_loading);
            check($sformatf("v%0d_dirty", i), DIRTY, vecs[i].exp_dirty);
            check($sformatf("v%0d_seq", i), seq_err, 0);
            check($sformatf("v%0d_overlap", i), overlap, 0);
            check($sformatf("v%0d_rd_noload", i), rd_noload, 0);
            check($sformatf("v%0d_error", i), ERROR, 0);
        end

        // Request latency and timeout with no acks
        ack_en = 0; BK_ENA = 1; RAM_MASK = 24'h001FFF;
        clear_mon();
        @(negedge CLK); LOAD_REQ = 1'b1;
        @(negedge CLK);
        check("lat_edge_n", SD_RD, 0);
        @(negedge CLK);
        LOAD_REQ = 1'b0;
        check("lat_edge_n1", SD_RD, 1);
        check("lat_loading", LOADING, 1);
        repeat (99) @(negedge CLK);
        check("to_before", {SD_RD, BUSY}, 2'b11);
        @(negedge CLK);
        check("to_rd", SD_RD, 0);
        check("to_error", ERROR, 1);
        check("to_busy", BUSY, 0);
        check("to_loading", LOADING, 0);
        check("to_done", done_cnt, 0);

        // Next accepted request clears ERROR; write mid-save leaves DIRTY set
        ack_en = 1; RAM_MASK = 24'h0007FF;
        clear_mon();
        SAVE_REQ = 1'b1;
        repeat (2) @(negedge CLK);
        check("err_clear", {ERROR, SD_WR}, 2'b01);
        SAVE_REQ = 1'b0;
        to = 1;
        for (int i = 0; i < 500; i++) begin
            @(negedge CLK);
            if (wr_reqs >= 2) begin to = 0; break; end
        end
        check("midsave_reach", to, 0);
        write_pulse();
        run_xfer(wb, to);
        check("midsave_timeout", to, 0);
        check("midsave_wr", wr_reqs, 4);
        check("midsave_done", done_cnt, 1);
        check("midsave_dirty", DIRTY, 1);
        check("midsave_loading", loading_seen, 0);

        // Autosave on OSD open when dirty, not when clean
        clear_mon();
        AUTOSAVE_EN = 1'b1;
        @(negedge CLK); OSD_STATUS = 1'b1;
        run_xfer(wb, to);
        check("auto_wr", wr_reqs, 4);
        check("auto_seq", seq_err, 0);
        check("auto_dirty", DIRTY, 0);
        OSD_STATUS = 1'b0;
        repeat (3) @(negedge CLK);
        clear_mon();
        OSD_STATUS = 1'b1;
        run_xfer(wb, to);
        check("auto_clean_busy", wb, 0);
        check("auto_clean_req", rd_reqs + wr_reqs, 0);
        OSD_STATUS = 1'b0; AUTOSAVE_EN = 1'b0;

        // SAVE_REQ rising while busy is dropped
        RAM_MASK = 24'h0003FF;
        clear_mon();
        @(negedge CLK); LOAD_REQ = 1'b1;
        repeat (8) @(negedge CLK);
        SAVE_REQ = 1'b1;
        LOAD_REQ = 1'b0;
        run_xfer(wb, to);
        repeat (20) @(negedge CLK);
        check("busy_save_wr", wr_reqs, 0);
        check("busy_save_rd", rd_reqs, 2);
        check("busy_save_idle", BUSY, 0);
        SAVE_REQ = 1'b0;

        // Async reset during the transfer of sector 5
        RAM_MASK = 24'h001FFF;
        write_pulse();
        clear_mon();
        @(negedge CLK); LOAD_REQ = 1'b1;
        to = 1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            LOAD_REQ = 1'b0;
            if (rd_reqs >= 6 && !SD_RD && BUSY) begin to = 0; break; end
        end
        check("rst5_reach", to, 0);
        check("rst5_lba", SD_LBA, 5);
        #2 RESET_N = 1'b0;
        #1;
        check("rst5_outs", {SD_RD, SD_WR, LOADING, BUSY, DIRTY, DONE, ERROR}, 0);
        check("rst5_lba0", SD_LBA, 0);
        @(negedge CLK); RESET_N = 1'b1;
        repeat (30) @(negedge CLK);
        clear_mon();
        repeat (60) @(negedge CLK);
        check("rst5_quiet", rd_reqs + wr_reqs, 0);
        check("rst5_idle", BUSY, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
